// File: rtl/resctrl_pkg.sv
// Shared types and constants for the polymoog resonator bypass controller.
// State encoding, mix width and ramp limits live here.
package resctrl_pkg;

  localparam int DEF_RES_LAT   = 5;
  localparam int DEF_RAMP_BITS = 8;
  localparam int DEF_WARMUP    = 8;
  localparam int RAMP_MAX      = 2 ** DEF_RAMP_BITS;
  localparam int SMP_W         = 16;
  localparam int MIX_W         = SMP_W + DEF_RAMP_BITS + 1;

  typedef enum logic [2:0] {
    ST_BYPASS   = 3'd0,
    ST_WARMUP   = 3'd1,
    ST_FADE_IN  = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_FADE_OUT = 3'd4
  } state_e;

  // Both fade directions report as "fading" on the 2-bit status port
  function automatic logic [1:0] state_code(state_e s);
    logic [2:0] r;
    r = s;
    return (s == ST_FADE_OUT) ? 2'd2 : r[1:0];
  endfunction

  function automatic logic [15:0] abs_sat(logic [15:0] v);
    if (v == 16'h8000) return 16'h7fff;
    return v[15] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/resctrl_xfade.sv
// Registered dry/wet crossfade: out = (wet*g + dry*(2**RAMP_BITS-g)) >>> RAMP_BITS.
// One cycle from valid_i to valid_o; floor rounding keeps g=0/g=max exact.
module resctrl_xfade
  import resctrl_pkg::*;
#(
  parameter int RAMP_BITS = DEF_RAMP_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  input  logic [15:0]        dry_i,
  input  logic [15:0]        wet_i,
  input  logic [RAMP_BITS:0] g_i,
  output logic [15:0]        out_o,
  output logic               valid_o
);

  localparam int GMAX = 1 << RAMP_BITS;

  logic signed [MIX_W-1:0] wet_x;
  logic signed [MIX_W-1:0] dry_x;
  logic signed [MIX_W-1:0] g_x;
  logic signed [MIX_W-1:0] h_x;
  logic signed [MIX_W-1:0] sum;
  logic signed [MIX_W-1:0] shf;
  logic [15:0]             out_d;
  logic [15:0]             out_q;
  logic                    valid_q;

  assign wet_x = MIX_W'($signed(wet_i));
  assign dry_x = MIX_W'($signed(dry_i));
  assign g_x   = MIX_W'(g_i);
  assign h_x   = MIX_W'(GMAX) - g_x;
  assign sum   = wet_x * g_x + dry_x * h_x;
  assign shf   = sum >>> RAMP_BITS;
  assign out_d = shf[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) out_q <= out_d;
    end
  end

  assign out_o   = out_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/polymoog_bypass_ctrl.sv
// Click-free engage/bypass sequencer for the polymoog resonator.
// Optional peak meter on the mixed output: define RESCTRL_PEAK_METER_EN.
module polymoog_bypass_ctrl
  import resctrl_pkg::*;
#(
  parameter int RES_LAT   = DEF_RES_LAT,
  parameter int RAMP_BITS = DEF_RAMP_BITS,
  parameter int WARMUP    = DEF_WARMUP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [15:0] dry_in,
  input  logic        bypass_req,
  output logic        res_en,
  output logic [15:0] res_in,
  input  logic [15:0] res_out,
  output logic [15:0] out_sample,
  output logic        out_valid,
  output logic [1:0]  state_o,
  output logic        overrun
`ifdef RESCTRL_PEAK_METER_EN
  ,
  output logic [15:0] peak_level,
  input  logic        peak_clr
`endif
);

  localparam int GW   = RAMP_BITS + 1;
  localparam int GMAX = 1 << RAMP_BITS;
  localparam int TW   = $clog2(RES_LAT + 1);
  localparam int WW   = $clog2(WARMUP + 1);

  state_e         state_q, state_d;
  logic [GW-1:0]  g_q, g_d;
  logic [WW-1:0]  wcnt_q, wcnt_d;
  logic [TW-1:0]  timer_q;
  logic [15:0]    dry_q;
  logic [15:0]    res_in_q;
  logic [15:0]    wet_q;
  logic           cap_q;
  logic           overrun_q;
  logic           accept;

  assign accept = sample_valid && (timer_q == '0);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    wcnt_d  = wcnt_q;
    if (accept) begin
      unique case (state_q)
        ST_BYPASS: begin
          g_d = '0;
          if (!bypass_req) begin
            state_d = ST_WARMUP;
            wcnt_d  = '0;
          end
        end
        ST_WARMUP: begin
          g_d    = '0;
          wcnt_d = wcnt_q + 1'b1;
          if (bypass_req) state_d = ST_BYPASS;
          else if (wcnt_d == WW'(WARMUP)) state_d = ST_FADE_IN;
        end
        ST_FADE_IN: begin
          if (bypass_req) begin
            state_d = ST_FADE_OUT;
          end else if (g_q >= GW'(GMAX - 1)) begin
            g_d     = GW'(GMAX);
            state_d = ST_ACTIVE;
          end else begin
            g_d = g_q + 1'b1;
          end
        end
        ST_ACTIVE: begin
          g_d = GW'(GMAX);
          if (bypass_req) state_d = ST_FADE_OUT;
        end
        ST_FADE_OUT: begin
          if (!bypass_req) begin
            state_d = ST_FADE_IN;
          end else if (g_q <= GW'(1)) begin
            g_d     = '0;
            state_d = ST_BYPASS;
          end else begin
            g_d = g_q - 1'b1;
          end
        end
        default: begin
          g_d     = '0;
          state_d = ST_BYPASS;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BYPASS;
      g_q     <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Capture timer: wet sample is taken as the timer steps 1 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      dry_q     <= '0;
      res_in_q  <= '0;
      wet_q     <= '0;
      cap_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cap_q <= (timer_q == TW'(1));
      if (accept) begin
        timer_q  <= TW'(RES_LAT);
        dry_q    <= dry_in;
        res_in_q <= dry_in;
      end else if (timer_q != '0) begin
        timer_q <= timer_q - 1'b1;
      end
      if (timer_q == TW'(1)) wet_q <= res_out;
      if (sample_valid && (timer_q != '0)) overrun_q <= 1'b1;
    end
  end

  resctrl_xfade #(
    .RAMP_BITS (RAMP_BITS)
  ) u_xfade (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (cap_q),
    .dry_i   (dry_q),
    .wet_i   (wet_q),
    .g_i     (g_q),
    .out_o   (out_sample),
    .valid_o (out_valid)
  );

  assign res_en  = (state_q != ST_BYPASS);
  assign res_in  = res_in_q;
  assign state_o = state_code(state_q);
  assign overrun = overrun_q;

`ifdef RESCTRL_PEAK_METER_EN
  logic [15:0] peak_q;
  logic [15:0] mag;

  assign mag = abs_sat(out_sample);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else if (peak_clr) begin
      peak_q <= '0;
    end else if (out_valid && (mag > peak_q)) begin
      peak_q <= mag;
    end
  end

  assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_polymoog_bypass_ctrl.sv
// Directed bench for polymoog_bypass_ctrl with a 4-stage resonator model.
// Define RESCTRL_PEAK_METER_EN to also exercise the peak meter.
`timescale 1ns/1ps
module tb_polymoog_bypass_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] dry_in = '0;
  logic        bypass_req = 1'b1;
  logic        res_en;
  logic [15:0] res_in;
  logic [15:0] res_out;
  logic [15:0] out_sample;
  logic        out_valid;
  logic [1:0]  state_o;
  logic        overrun;
`ifdef RESCTRL_PEAK_METER_EN
  logic [15:0] peak_level;
  logic        peak_clr = 1'b0;
`endif

  int vecs = 0;
  int errs = 0;

  logic [15:0] d1, d2, d3, d4;
  logic        force_en = 1'b0;
  logic [15:0] force_val = '0;

  polymoog_bypass_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .dry_in       (dry_in),
    .bypass_req   (bypass_req),
    .res_en       (res_en),
    .res_in       (res_in),
    .res_out      (res_out),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .state_o      (state_o),
    .overrun      (overrun)
`ifdef RESCTRL_PEAK_METER_EN
    ,
    .peak_level   (peak_level),
    .peak_clr     (peak_clr)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] res_model(logic signed [15:0] x);
    return (x >>> 1) - 16'sd3000;
  endfunction

  function automatic logic [15:0] mix_ref(int dry, int wet, int g);
    int s;
    s = wet * g + dry * (256 - g);
    return 16'(s >>> 8);
  endfunction

  always @(posedge clk) begin
    d1 <= res_model(res_in);
    d2 <= d1;
    d3 <= d2;
    d4 <= d3;
  end
  assign res_out = force_en ? force_val : d4;

  // bypass_req and dry_in are scrambled between strobes on purpose
  task automatic strobe(input logic [15:0] d, input logic breq,
                        output logic [15:0] got, output int lat);
    @(negedge clk);
    dry_in = d; bypass_req = breq; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0; bypass_req = ~breq; dry_in = ~d;
    lat = 0; got = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i; got = out_sample;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; force_en = 1'b0; sample_valid = 1'b0; bypass_req = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({res_en, out_valid, overrun, state_o} !== 5'b0) begin
      errs++;
      $display("FAIL reset_ctrl: got en=%b v=%b ov=%b st=%0d want 0", res_en, out_valid, overrun, state_o);
    end
    vecs++;
    if (res_in !== 16'd0 || out_sample !== 16'd0) begin
      errs++;
      $display("FAIL reset_data: got res_in=%h out=%h want 0", res_in, out_sample);
    end
`ifdef RESCTRL_PEAK_METER_EN
    vecs++;
    if (peak_level !== 16'd0) begin
      errs++;
      $display("FAIL reset_peak: got %h want 0", peak_level);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    logic [15:0] got;
    logic [15:0] vals [4];
    int lat;
    vals = '{16'd1000, 16'd1000, 16'hfffb, 16'd1000};
    for (int k = 0; k < 4; k++) begin
      strobe(vals[k], 1'b1, got, lat);
      vecs++;
      if (got !== vals[k] || lat != 6) begin
        errs++;
        $display("FAIL bypass_out[%0d]: got %h lat %0d want %h lat 6", k, got, lat, vals[k]);
      end
      vecs++;
      if (res_en !== 1'b0 || state_o !== 2'd0) begin
        errs++;
        $display("FAIL bypass_state[%0d]: got en=%b st=%0d want en=0 st=0", k, res_en, state_o);
      end
    end
  endtask

  task automatic test_engage();
    logic [15:0] got, dry, exp;
    int lat, g;
    do_reset();
    for (int k = 1; k <= 268; k++) begin
      dry = 16'(k * 97 - 13000);
      g = (k <= 9) ? 0 : ((k - 9 > 256) ? 256 : k - 9);
      strobe(dry, 1'b0, got, lat);
      exp = mix_ref(int'($signed(dry)), int'(res_model(dry)), g);
      vecs++;
      if (got !== exp || lat != 6) begin
        errs++;
        $display("FAIL engage_out[%0d]: got %h lat %0d want %h lat 6", k, got, lat, exp);
      end
      if (k == 1 || k == 9 || k == 264 || k == 265) begin
        logic [1:0] st;
        st = (k == 1) ? 2'd1 : (k == 265) ? 2'd3 : 2'd2;
        vecs++;
        if (state_o !== st || res_en !== 1'b1) begin
          errs++;
          $display("FAIL engage_state[%0d]: got st=%0d en=%b want st=%0d en=1", k, state_o, res_en, st);
        end
      end
    end
  endtask

  task automatic test_fade_out();
    logic [15:0] got, exp;
    int lat, prev, step, maxstep;
    do_reset();
    for (int k = 1; k <= 109; k++) strobe(16'd8000, 1'b0, got, lat);
    exp = mix_ref(8000, 1000, 100);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL fade_g100: got %h want %h", got, exp);
    end
    prev = int'($signed(got));
    maxstep = 0;
    for (int j = 0; j <= 100; j++) begin
      strobe(16'd8000, 1'b1, got, lat);
      exp = mix_ref(8000, 1000, 100 - j);
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL fade_out[%0d]: got %h want %h", j, got, exp);
      end
      step = int'($signed(got)) - prev;
      if (step < 0) step = -step;
      if (step > maxstep) maxstep = step;
      prev = int'($signed(got));
      if (j == 99) begin
        vecs++;
        if (res_en !== 1'b1) begin
          errs++;
          $display("FAIL fade_en_g1: got %b want 1", res_en);
        end
      end
    end
    vecs++;
    if (res_en !== 1'b0 || state_o !== 2'd0 || got !== 16'd8000) begin
      errs++;
      $display("FAIL fade_end: got en=%b st=%0d out=%h want en=0 st=0 out=1f40", res_en, state_o, got);
    end
    vecs++;
    if (maxstep > 28) begin
      errs++;
      $display("FAIL fade_step: got %0d want <= 28", maxstep);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] got, val;
    int lat, cnt;
    do_reset();
    vecs++;
    if (overrun !== 1'b0) begin
      errs++;
      $display("FAIL overrun_init: got %b want 0", overrun);
    end
    @(negedge clk);
    dry_in = 16'd500; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    dry_in = 16'd700; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    cnt = 0; val = '0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        cnt++; val = out_sample;
      end
    end
    vecs++;
    if (cnt != 1 || val !== 16'd500) begin
      errs++;
      $display("FAIL overrun_single: got %0d outputs val %h want 1 val 01f4", cnt, val);
    end
    vecs++;
    if (overrun !== 1'b1) begin
      errs++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    strobe(16'd300, 1'b1, got, lat);
    vecs++;
    if (overrun !== 1'b1 || got !== 16'd300) begin
      errs++;
      $display("FAIL overrun_sticky: got ov=%b out=%h want ov=1 out=012c", overrun, got);
    end
  endtask

  task automatic test_extreme();
    logic [15:0] got;
    int lat;
    do_reset();
    force_en = 1'b1; force_val = 16'h7fff;
    for (int k = 1; k <= 265; k++) begin
      strobe(16'h8000, 1'b0, got, lat);
      if (k == 1) begin
        vecs++;
        if (got !== 16'h8000) begin
          errs++;
          $display("FAIL extreme_g0: got %h want 8000", got);
        end
`ifdef RESCTRL_PEAK_METER_EN
        @(posedge clk); #1;
        vecs++;
        if (peak_level !== 16'h7fff) begin
          errs++;
          $display("FAIL peak_sat: got %h want 7fff", peak_level);
        end
        @(negedge clk); peak_clr = 1'b1;
        @(negedge clk); peak_clr = 1'b0;
        vecs++;
        if (peak_level !== 16'd0) begin
          errs++;
          $display("FAIL peak_clr: got %h want 0", peak_level);
        end
`endif
      end
      if (k == 137) begin
        vecs++;
        if (got !== 16'hffff) begin
          errs++;
          $display("FAIL extreme_g128: got %h want ffff", got);
        end
      end
    end
    vecs++;
    if (got !== 16'h7fff || state_o !== 2'd3) begin
      errs++;
      $display("FAIL extreme_g256: got %h st=%0d want 7fff st=3", got, state_o);
    end
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    int lat;
    do_reset();
    for (int k = 1; k <= 20; k++) strobe(16'd2000, 1'b0, got, lat);
    strobe(16'd2000, 1'b1, got, lat);
    strobe(16'd2000, 1'b1, got, lat);
    vecs++;
    if (res_en !== 1'b1 || got === 16'd0) begin
      errs++;
      $display("FAIL midreset_pre: got en=%b out=%h want en=1 out!=0", res_en, got);
    end
    @(negedge clk);
    dry_in = 16'd2000; bypass_req = 1'b1; sample_valid = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0; sample_valid = 1'b0;
    #1;
    vecs++;
    if ({res_en, out_valid, overrun, state_o} !== 5'b0 || res_in !== 16'd0 || out_sample !== 16'd0) begin
      errs++;
      $display("FAIL midreset_async: got en=%b v=%b st=%0d res_in=%h out=%h want all 0",
               res_en, out_valid, state_o, res_in, out_sample);
    end
    @(negedge clk);
    rst_n = 1'b1;
    strobe(16'd1234, 1'b0, got, lat);
    vecs++;
    if (got !== 16'd1234 || lat != 6) begin
      errs++;
      $display("FAIL midreset_dry: got %h lat %0d want 04d2 lat 6", got, lat);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_engage();
    test_fade_out();
    test_overrun();
    test_extreme();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
